// File: rtl/ysyx_24100012_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, func3 access codes and
// writeback select codes.
package ysyx_24100012_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WBALU  = 2'd0;
  localparam logic [1:0] WBPc   = 2'd1;
  localparam logic [1:0] WBLoad = 2'd2;
  localparam logic [1:0] WBNone = 2'd3;

endpackage

// File: rtl/ysyx_24100012_lsu_align.sv
// Combinational byte-lane logic: legality/misalignment check, store strobes and lane
// replication, and load extraction with sign/zero extension.
module ysyx_24100012_lsu_align
  import ysyx_24100012_lsu_pkg::*;
(
  input  logic        ren,
  input  logic        wen,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic        illegal;
  logic        misaligned;
  logic [15:0] sh;

  always_comb begin
    illegal = 1'b0;
    if (ren && wen) begin
      illegal = 1'b1;
    end else if (ren) begin
      illegal = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else if (wen) begin
      illegal = !(func3 inside {F3_B, F3_H, F3_W});
    end

    // func3[1:0] encodes the access size for every legal code
    unique case (func3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase

    err = (ren || wen) && (illegal || misaligned);
  end

  always_comb begin
    unique case (func3[1:0])
      2'b00: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  always_comb begin
    sh = 16'(rdata >> {addr_lo, 3'b000});
    unique case (func3)
      F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   rdata_ext = {24'd0, sh[7:0]};
      F3_H:    rdata_ext = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   rdata_ext = {16'd0, sh[15:0]};
      F3_W:    rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: accepts one decoded memory access, runs it over a single-outstanding
// valid/ready bus and returns extended load data or an error to writeback.
module ysyx_24100012_lsu
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_ren,
  input  logic                  req_wen,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rsp_err
);

  lsu_state_e            state_q, state_d;
  logic                  ren_q, ren_d, wen_q, wen_d;
  logic [2:0]            func3_q, func3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  idle, in_req, in_resp;
  logic                  sel_ren, sel_wen;
  logic [2:0]            sel_func3;
  logic [1:0]            sel_addr_lo;
  logic                  align_err;
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_wdata, load_ext;

  assign idle    = (state_q == StIdle);
  assign in_req  = (state_q == StReq);
  assign in_resp = (state_q == StResp);

  // Legality is judged on the incoming request while idle, on the latched one afterwards
  always_comb begin
    sel_ren     = idle ? req_ren       : ren_q;
    sel_wen     = idle ? req_wen       : wen_q;
    sel_func3   = idle ? req_func3     : func3_q;
    sel_addr_lo = idle ? req_addr[1:0] : addr_q[1:0];
  end

  ysyx_24100012_lsu_align u_align (
    .ren        (sel_ren),
    .wen        (sel_wen),
    .func3      (sel_func3),
    .addr_lo    (sel_addr_lo),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .err        (align_err),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_ext)
  );

  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          ren_d   = req_ren;
          wen_d   = req_wen;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = align_err;
          // Errors and no-ops complete without touching the bus
          state_d = (align_err || !(req_ren ^ req_wen)) ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          err_d   = mem_rsp_err;
          rdata_d = (ren_q && !mem_rsp_err) ? load_ext : '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = idle;
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wen       = in_req && wen_q;
  assign mem_wdata     = (in_req && wen_q) ? lane_wdata : '0;
  assign mem_wstrb     = (in_req && wen_q) ? lane_strb : 4'b0000;
  assign rsp_valid     = in_resp;
  assign rsp_rdata     = in_resp ? rdata_q : '0;
  assign rsp_err       = in_resp && err_q;

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Directed plus randomized bench for the load/store unit against an arithmetic reference
// model of access legality, strobes, lane replication and load extension.
module tb_ysyx_24100012_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_ren, req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24100012_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ren       (req_ren),
    .req_wen       (req_wen),
    .req_func3     (req_func3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // Reference: access size from func3, misalignment by modulo, lanes by arithmetic
  function automatic void model(input logic ren, input logic wen, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic bus, output logic err,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] rd);
    int      size = 0;
    int      off;
    bit      sgn;
    longint  v, span;
    off = int'(addr % 4);
    sgn = (f3 == 3'd0 || f3 == 3'd1);
    if (ren && !wen) begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
    end else if (wen && !ren) begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: size = 0;
      endcase
    end
    bus = 0; err = 0; strb = 0; wd = 0; rd = 0;
    if (!ren && !wen) return;
    if (size == 0 || (off % size) != 0) begin
      err = 1;
      return;
    end
    bus = 1;
    if (wen) begin
      strb = 4'(((1 << size) - 1) << off);
      if (size == 1)      wd = wdata[7:0] * 32'h0101_0101;
      else if (size == 2) wd = wdata[15:0] * 32'h0001_0001;
      else                wd = wdata;
    end else if (size == 4) begin
      rd = rdata;
    end else begin
      span = longint'(1) << (8 * size);
      v = longint'(rdata >> (8 * off)) % span;
      if (sgn && v >= span / 2) v = v - span;
      rd = 32'(v);
    end
  endfunction

  task automatic access(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic berr, input int req_dly,
                        input int wait_dly, input int rsp_dly);
    logic        e_bus, e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;
    model(ren, wen, f3, addr, wdata, rdata, e_bus, e_err, e_strb, e_wd, e_rd);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; req_ren = ren; req_wen = wen; req_func3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble request inputs: the LSU must work from its latched copy
    req_valid = 0; req_ren = 1'($urandom); req_wen = 1'($urandom);
    req_func3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (e_bus) begin
      for (int k = 0; k <= req_dly; k++) begin
        chk("req_mem_req_valid", mem_req_valid, 1);
        chk("req_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_mem_wen", mem_wen, wen);
        chk("req_mem_wstrb", mem_wstrb, e_strb);
        if (wen) chk("req_mem_wdata", mem_wdata, e_wd);
        chk("req_req_ready", req_ready, 0);
        chk("req_rsp_valid", rsp_valid, 0);
        mem_req_ready = (k == req_dly);
        mem_rsp_valid = 1'($urandom);
        mem_rdata = $urandom;
        mem_rsp_err = 1'($urandom);
        @(posedge clk); #1;
      end
      mem_req_ready = 0;
      for (int k = 0; k <= wait_dly; k++) begin
        chk("wait_mem_req_valid", mem_req_valid, 0);
        chk("wait_rsp_valid", rsp_valid, 0);
        chk("wait_req_ready", req_ready, 0);
        mem_rsp_valid = (k == wait_dly);
        mem_rdata = (k == wait_dly) ? rdata : $urandom;
        mem_rsp_err = (k == wait_dly) ? berr : 1'($urandom);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 0; mem_rsp_err = 0; mem_rdata = $urandom;
      if (berr) begin
        e_err = 1;
        e_rd = 0;
      end
    end else begin
      chk("nobus_mem_req_valid", mem_req_valid, 0);
    end
    for (int k = 0; k <= rsp_dly; k++) begin
      chk("resp_rsp_valid", rsp_valid, 1);
      chk("resp_rsp_err", rsp_err, e_err);
      chk("resp_rsp_rdata", rsp_rdata, e_rd);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_mem_req_valid", mem_req_valid, 0);
      rsp_ready = (k == rsp_dly);
      if (k == rsp_dly) begin
        // A request offered during the handshake must be ignored
        req_valid = 1; req_ren = 1; req_wen = 0; req_func3 = 3'd2; req_addr = 32'h8000_0000;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 0; req_valid = 0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_mem_req_valid", mem_req_valid, 0);
  endtask

  initial begin
    logic [2:0] sel;
    logic       r, w;
    rst_n = 0;
    req_valid = 0; req_ren = 0; req_wen = 0; req_func3 = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_rsp_err = 0;
    #12;
    chk_quiet("reset");
    rst_n = 1;
    @(posedge clk); #1;
    chk_quiet("after_reset");

    // LB with sign extension of the top byte
    access(1, 0, 3'd0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 0);
    access(1, 0, 3'd5, 32'h8000_0002, 32'h0, 32'h9234_5678, 0, 0, 0, 0);
    access(1, 0, 3'd1, 32'h8000_0002, 32'h0, 32'h9234_5678, 0, 0, 0, 0);
    access(0, 1, 3'd0, 32'h8000_0001, 32'h1234_56AB, 32'h0, 0, 0, 0, 0);
    access(0, 1, 3'd1, 32'h8000_0002, 32'h1234_56AB, 32'h0, 0, 0, 0, 0);
    access(0, 1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0);
    access(1, 0, 3'd2, 32'h8000_0002, 32'h0, 32'h1111_1111, 0, 0, 0, 0);
    access(0, 1, 3'd1, 32'h8000_0003, 32'h0, 32'h0, 0, 0, 0, 0);
    access(1, 0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    access(0, 1, 3'd4, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    access(1, 1, 3'd2, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    access(0, 0, 3'd2, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    // Bus stalls, then a bus error
    access(0, 1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 0, 5, 0, 3);
    access(1, 0, 3'd2, 32'h8000_0020, 32'h0, 32'h1234_5678, 1, 1, 2, 1);

    // Reset while waiting for the bus response
    req_valid = 1; req_ren = 1; req_wen = 0; req_func3 = 3'd2; req_addr = 32'h8000_0040;
    @(posedge clk); #1;
    req_valid = 0;
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    chk("midrst_wait_req_ready", req_ready, 0);
    rst_n = 0;
    #1;
    chk_quiet("midrst_in_reset");
    #2 rst_n = 1;
    @(posedge clk); #1;
    mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk_quiet("midrst_stale_rsp");
    access(1, 0, 3'd2, 32'h8000_0044, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = 3'($urandom);
      r = (sel <= 3'd2) || (sel == 3'd6);
      w = (sel inside {3'd3, 3'd4, 3'd5, 3'd6});
      access(r, w, 3'($urandom), $urandom, $urandom, $urandom, ($urandom % 6) == 0,
             int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
